multdiv_ctrl: RTL and testbench

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequential signed 32x32 multiply / divide controller that
// borrows an external 32-bit carry-lookahead adder, one operation at a time.
// Every accepted operation walks IDLE -> LOAD(2) -> ITER(32) -> FIX -> DONE,
// so data_resultRDY pulses a fixed 36 cycles after the accept edge.
// Build option: define MULTDIV_DIVIDE_EN to include the restoring-divide
// datapath. Without it, an accepted divide reports data_exception=1 and
// data_result=0 one cycle after accept.
// Handshake: a start (ctrl_MULT/ctrl_DIV) is taken only while busy=0; starts
// seen while busy=1 are dropped. data_result/data_exception are valid on the
// single-cycle data_resultRDY pulse and hold until the next accepted start.
module multdiv_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] adder_a,
    output logic [31:0] adder_b,
    output logic        adder_sub,
    output logic        adder_en,
    input  logic [31:0] adder_sum,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    state_t      state;
    logic        load_step;   // 0: magnitude of A, 1: magnitude of B
    logic [4:0]  cnt;
    logic        sign;        // sign of the final result
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] prod;        // mult: {high, multiplier}; div: {rem, quo}
    logic [31:0] mcand;       // multiplicand or divisor magnitude
    logic [31:0] res_q;
    logic        exc_q;
    logic [31:0] ld_x;
    logic        mul_cout;
    logic        mult_ovf;
`ifdef MULTDIV_DIVIDE_EN
    logic        is_div;
    logic        div0;
    logic        div_borrow;
`endif

    assign dbg_state = state;

    // Carry out of the unsigned add, rebuilt from the adder's top bits.
    assign mul_cout = (adder_a[31] & adder_b[31]) |
                      ((adder_a[31] ^ adder_b[31]) & ~adder_sum[31]);

    // Product magnitude does not fit the signed 32-bit range.
    assign mult_ovf = sign ? ((|prod[63:32]) | (prod[31] & (|prod[30:0])))
                           : (|prod[63:31]);

`ifdef MULTDIV_DIVIDE_EN
    // Borrow out of a-b: set when the shifted remainder is below the divisor.
    assign div_borrow = (~adder_a[31] & adder_b[31]) |
                        (~(adder_a[31] ^ adder_b[31]) & adder_sum[31]);
`endif

    // Adder operand steering; all drives are zero outside LOAD/ITER/FIX.
    always_comb begin
        adder_a   = '0;
        adder_b   = '0;
        adder_sub = 1'b0;
        adder_en  = 1'b0;
        ld_x      = load_step ? op_b : op_a;
        case (state)
            ST_LOAD: begin
                adder_en  = 1'b1;
                adder_sub = ld_x[31];
                adder_a   = ld_x[31] ? '0 : ld_x;
                adder_b   = ld_x[31] ? ld_x : '0;
            end
            ST_ITER: begin
                adder_en = 1'b1;
`ifdef MULTDIV_DIVIDE_EN
                if (is_div) begin
                    adder_a   = prod[62:31];
                    adder_b   = mcand;
                    adder_sub = 1'b1;
                end else begin
                    adder_a = prod[63:32];
                    adder_b = prod[0] ? mcand : '0;
                end
`else
                adder_a = prod[63:32];
                adder_b = prod[0] ? mcand : '0;
`endif
            end
            ST_FIX: begin
                adder_en  = 1'b1;
                adder_sub = sign;
                adder_a   = sign ? '0 : prod[31:0];
                adder_b   = sign ? prod[31:0] : '0;
            end
            default: begin
                adder_en = 1'b0;
            end
        endcase
    end

    // Control FSM with the datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            load_step      <= 1'b0;
            cnt            <= '0;
            sign           <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            prod           <= '0;
            mcand          <= '0;
            res_q          <= '0;
            exc_q          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
`ifdef MULTDIV_DIVIDE_EN
            is_div         <= 1'b0;
            div0           <= 1'b0;
`endif
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ctrl_MULT || ctrl_DIV) begin
                        op_a           <= data_operandA;
                        op_b           <= data_operandB;
                        sign           <= data_operandA[31] ^ data_operandB[31];
                        load_step      <= 1'b0;
                        cnt            <= '0;
                        data_result    <= '0;
                        data_exception <= 1'b0;
                        busy           <= 1'b1;
`ifdef MULTDIV_DIVIDE_EN
                        is_div         <= ~ctrl_MULT;
                        state          <= ST_LOAD;
`else
                        if (ctrl_MULT) begin
                            state <= ST_LOAD;
                        end else begin
                            res_q <= '0;
                            exc_q <= 1'b1;
                            state <= ST_DONE;
                        end
`endif
                    end
                end
                ST_LOAD: begin
                    if (!load_step) begin
                        prod      <= {32'b0, adder_sum};
                        load_step <= 1'b1;
                    end else begin
                        mcand <= adder_sum;
`ifdef MULTDIV_DIVIDE_EN
                        div0  <= (adder_sum == '0);
`endif
                        state <= ST_ITER;
                    end
                end
                ST_ITER: begin
`ifdef MULTDIV_DIVIDE_EN
                    if (is_div) begin
                        if (!div_borrow) prod <= {adder_sum, prod[30:0], 1'b1};
                        else             prod <= {adder_a, prod[30:0], 1'b0};
                    end else begin
                        prod <= {mul_cout, adder_sum, prod[31:1]};
                    end
`else
                    prod <= {mul_cout, adder_sum, prod[31:1]};
`endif
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_ITER) state <= ST_FIX;
                end
                ST_FIX: begin
`ifdef MULTDIV_DIVIDE_EN
                    if (is_div) begin
                        res_q <= div0 ? '0 : adder_sum;
                        exc_q <= div0 | (~sign & prod[31]);
                    end else begin
                        res_q <= adder_sum;
                        exc_q <= mult_ovf;
                    end
`else
                    res_q <= adder_sum;
                    exc_q <= mult_ovf;
`endif
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    data_result    <= res_q;
                    data_exception <= exc_q;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: drives multiply/divide operations into multdiv_ctrl with a
// behavioural model of the shared adder, and scores every result pulse
// against values computed from plain signed arithmetic.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic        adder_sub;
    logic        adder_en;
    logic [31:0] adder_sum;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [2:0]  dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic [32:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] last_res = '0;
    logic        last_exc = 1'b0;

    multdiv_ctrl #(.ITER(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .adder_a        (adder_a),
        .adder_b        (adder_b),
        .adder_sub      (adder_sub),
        .adder_en       (adder_en),
        .adder_sum      (adder_sum),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // Shared carry-lookahead adder, behavioural.
    always_comb begin
        adder_sum = adder_a;
        if (adder_en) adder_sum = adder_sub ? (adder_a - adder_b) : (adder_a + adder_b);
    end

    // Clock and cycle index (cyc = number of rising edges so far).
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: {exception, result} from signed arithmetic.
    function automatic logic [32:0] model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     sa;
        int     sb;
        int     q;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p > longint'(2147483647)) || (p < (longint'(-2147483647) - 1)), p[31:0]};
        end
`ifdef MULTDIV_DIVIDE_EN
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        return {1'b0, 32'(q)};
`else
        sa = 0;
        sb = 0;
        q  = 0;
        return {1'b1, 32'd0};
`endif
    endfunction

    // Scoreboard: every result pulse must match the oldest expectation.
    always @(negedge clock) begin
        logic [32:0] e;
        int          c;
        if (data_resultRDY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 64'(data_resultRDY), 64'd0);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("rdy_cycle", 64'(cyc), 64'(c));
                check("result", 64'(data_result), 64'(e[31:0]));
                check("exception", 64'(data_exception), 64'(e[32]));
                last_res = e[31:0];
                last_exc = e[32];
            end
        end
    end

    // Issue one start when idle; called and returns at a falling edge.
    task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (busy && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        last_acc = cyc;
        exp_q.push_back(model(m, a, b));
`ifdef MULTDIV_DIVIDE_EN
        exp_cyc_q.push_back(last_acc + 36);
`else
        exp_cyc_q.push_back(last_acc + (m ? 36 : 1));
`endif
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Wait for all expected results, then confirm they are held.
    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clock);
            guard++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge clock);
        check("rdy_low", 64'(data_resultRDY), 64'd0);
        check("hold_result", 64'(data_result), 64'(last_res));
        check("hold_exception", 64'(data_exception), 64'(last_exc));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, 64'(data_result), 64'd0);
        check({tag, "_exception"}, 64'(data_exception), 64'd0);
        check({tag, "_rdy"}, 64'(data_resultRDY), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_adder_en"}, 64'(adder_en), 64'd0);
        check({tag, "_adder_a"}, 64'(adder_a), 64'd0);
        check({tag, "_adder_b"}, 64'(adder_b), 64'd0);
        check({tag, "_adder_sub"}, 64'(adder_sub), 64'd0);
    endtask

    initial begin
        int a1;
        logic [31:0] ra;
        logic [31:0] rb;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // 7 * -6 = -42
        do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
        drain();

        // Overflow, then the most negative product, issued back to back.
        do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        a1 = last_acc;
        do_op(1'b1, 1'b0, 32'h8000_0000, 32'd1);
        check("b2b_period", 64'(last_acc - a1), 64'd37);
        do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();

`ifdef MULTDIV_DIVIDE_EN
        do_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        do_op(1'b0, 1'b1, 32'd5, 32'd0);
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'd1);
        do_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
        drain();
`else
        do_op(1'b0, 1'b1, 32'd10, 32'd2);
        drain();
`endif

        // Both starts high: multiply wins; a divide pulse while busy is dropped.
        do_op(1'b1, 1'b1, 32'd3, 32'd4);
        repeat (9) @(negedge clock);
        check("busy_mid_op", 64'(busy), 64'd1);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd0;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        drain();
        repeat (40) @(negedge clock);

        // Reset at accept+20 aborts; a start during reset is ignored.
        do_op(1'b1, 1'b0, 32'h0000_1234, 32'h0000_5678);
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
        repeat (19) @(negedge clock);
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(posedge clock);
        #1;
        check_all_zero("abort");
        @(negedge clock);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        check("abort_idle", 64'(busy), 64'd0);
        last_res = '0;
        last_exc = 1'b0;
        do_op(1'b1, 1'b0, 32'd2, 32'd3);
        drain();

        // Random multiplies: full-range and small signed operands.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom();
            rb = $urandom();
            do_op(1'b1, 1'b0, ra, rb);
            ra = 32'($urandom_range(0, 65535));
            rb = 32'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            do_op(1'b1, 1'b0, ra, rb);
        end
        drain();

`ifdef MULTDIV_DIVIDE_EN
        for (int i = 0; i < 6; i++) begin
            ra = $urandom();
            rb = 32'($urandom_range(1, 5000));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            do_op(1'b0, 1'b1, ra, rb);
        end
        drain();
`endif

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
